fade_scheduler: RTL

//  Time-multiplexed fade controller for multiple PWM LED channels sharing one gamma LUT BRAM.
//  - Per channel: prescaled triangle-wave position generator.
//  - On each prescaler tick, sweeps enabled channels round-robin:
//    - reads the shared gamma LUT (single read port, 1-cycle latency);
//    - latches the corrected level for that channel's pwm instance.
//  - Sits between the clk60 domain PLL output and the gamma bram / pwm instances.

---
 rtl/fade_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fade_scheduler.sv
// fade_scheduler: per-channel triangle fade generator that time-shares one gamma LUT read port.
// Optional build macro GAMMA_BYPASS_EN adds a gamma_bypass input that routes the raw triangle to level.
//
// state   | meaning
// IDLE    | waiting for a prescaler tick
// ISSUE   | LUT read in flight for channel idx
// CAPTURE | LUT data valid, latch level[idx], pick next channel
module fade_scheduler #(
  parameter int CHANNELS   = 2,
  parameter int PWM_WIDTH  = 8,
  parameter int PRESCALE   = 300000,
  parameter int PRESCALE_W = 26
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           ch_en,
`ifdef GAMMA_BYPASS_EN
  input  logic                          gamma_bypass,
`endif
  output logic                          lut_en,
  output logic [PWM_WIDTH-1:0]          lut_addr,
  input  logic [PWM_WIDTH-1:0]          lut_data,
  output logic [CHANNELS*PWM_WIDTH-1:0] level,
  output logic [CHANNELS-1:0]           level_valid,
  output logic                          busy
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int POS_W = PWM_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic                  pending;
  logic [IDX_W-1:0]      idx;
  logic [POS_W-1:0]      pos     [CHANNELS];
  logic [POS_W-1:0]      pos_nxt [CHANNELS];
  logic [PWM_WIDTH-1:0]  lvl     [CHANNELS];
  logic                  lo_found, nx_found;
  logic [IDX_W-1:0]      lo_idx, nx_idx;
  logic [PWM_WIDTH-1:0]  lo_tri, nx_tri;
  logic                  issue_go;
  logic [IDX_W-1:0]      issue_idx;
  logic [PWM_WIDTH-1:0]  issue_tri;
  logic [PWM_WIDTH-1:0]  cap_data;
  logic                  use_lut;

  function automatic logic [PWM_WIDTH-1:0] tri_of(input logic [POS_W-1:0] p);
    return p[PWM_WIDTH] ? ~p[PWM_WIDTH-1:0] : p[PWM_WIDTH-1:0];
  endfunction

  // Channels start evenly spread around the triangle period.
  function automatic logic [POS_W-1:0] pos_init(input int i);
    return POS_W'((i * (1 << POS_W)) / CHANNELS);
  endfunction

  assign tick = enable && (pre_cnt == PRESCALE_W'(PRESCALE - 1));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pos_nxt[i] = pos[i] + POS_W'(tick && ch_en[i]);
    end
  end

  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    nx_found = 1'b0;
    nx_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
      if (ch_en[i] && (i > int'(idx))) begin
        nx_found = 1'b1;
        nx_idx   = IDX_W'(i);
      end
    end
  end

  // Addresses always come from post-tick positions so a tick in the issue cycle is honoured.
  assign lo_tri = tri_of(pos_nxt[lo_idx]);
  assign nx_tri = tri_of(pos_nxt[nx_idx]);

  always_comb begin
    issue_go  = 1'b0;
    issue_idx = lo_idx;
    issue_tri = lo_tri;
    case (state)
      S_IDLE:    issue_go = tick && lo_found;
      S_CAPTURE: begin
        if (nx_found) begin
          issue_go  = 1'b1;
          issue_idx = nx_idx;
          issue_tri = nx_tri;
        end else begin
          issue_go = (pending || tick) && lo_found;
        end
      end
      default:   issue_go = 1'b0;
    endcase
  end

`ifdef GAMMA_BYPASS_EN
  logic [PWM_WIDTH-1:0] tri_q;

  assign use_lut  = !gamma_bypass;
  assign cap_data = gamma_bypass ? tri_q : lut_data;

  always_ff @(posedge clk) begin
    if (!rst_n)        tri_q <= '0;
    else if (issue_go) tri_q <= issue_tri;
  end
`else
  assign use_lut  = 1'b1;
  assign cap_data = lut_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      pending     <= 1'b0;
      idx         <= '0;
      lut_en      <= 1'b0;
      lut_addr    <= '0;
      level_valid <= '0;
      busy        <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pos[i] <= pos_init(i);
        lvl[i] <= '0;
      end
    end else begin
      if (enable) pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
      for (int i = 0; i < CHANNELS; i++) pos[i] <= pos_nxt[i];
      level_valid <= '0;
      lut_en      <= 1'b0;

      if (issue_go) begin
        state  <= S_ISSUE;
        busy   <= 1'b1;
        idx    <= issue_idx;
        lut_en <= use_lut;
        if (use_lut) lut_addr <= issue_tri;
      end

      case (state)
        S_IDLE: ;
        S_ISSUE: begin
          state <= S_CAPTURE;
          if (tick) pending <= 1'b1;
        end
        S_CAPTURE: begin
          lvl[idx]         <= cap_data;
          level_valid[idx] <= 1'b1;
          // A tick landing exactly as the pending one is consumed stays queued.
          if (nx_found) begin
            if (tick) pending <= 1'b1;
          end else if (issue_go) begin
            pending <= pending & tick;
          end else begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < CHANNELS; i++) level[i*PWM_WIDTH +: PWM_WIDTH] = lvl[i];
  end

endmodule
